// File: rtl/mandelbrot_iter_engine.sv
// Mandelbrot iteration engine: iterates Z <= Z^2 + C from Z=0 for one point,
// reporting escape and iteration count, with a shift-in preload buffer for C.
module mandelbrot_iter_engine #(
   parameter int WIDTH  = 32,
   parameter int FRAC   = 28,
   parameter int IN_W   = 4,
   parameter int ITER_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift_en,
   input  logic [IN_W-1:0]   cr_in,
   input  logic [IN_W-1:0]   ci_in,
   input  logic              start,
   input  logic [ITER_W-1:0] max_iter,
   output logic              busy,
   output logic              done,
   output logic              escaped,
   output logic [ITER_W-1:0] iter_count
);

   if (WIDTH - FRAC < 4) begin : g_bad_frac
      $error("WIDTH-FRAC must be >= 4");
   end
   if (WIDTH % IN_W != 0) begin : g_bad_in_w
      $error("WIDTH must be a multiple of IN_W");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic signed [2*WIDTH:0] FOUR =
      (2*WIDTH+1)'(4) << (2*FRAC);

   state_t state_q, state_d;

   logic signed [WIDTH-1:0] zr_q, zr_d;
   logic signed [WIDTH-1:0] zi_q, zi_d;
   logic signed [WIDTH-1:0] cr_q, cr_d;
   logic signed [WIDTH-1:0] ci_q, ci_d;
   logic [WIDTH-1:0]        crb_q, crb_d;
   logic [WIDTH-1:0]        cib_q, cib_d;
   logic [ITER_W-1:0]       cnt_q, cnt_d;
   logic [ITER_W-1:0]       max_q, max_d;
   logic [ITER_W-1:0]       iter_q, iter_d;
   logic                    esc_q, esc_d;

   // Full-precision products; magnitude keeps one extra bit so it never wraps.
   logic signed [2*WIDTH-1:0] zr2, zi2, zri;
   logic signed [2*WIDTH:0]   diff_w, twice_w, mag_w;
   logic signed [WIDTH-1:0]   zr_nxt, zi_nxt;

   always_comb begin
      zr2     = zr_q * zr_q;
      zi2     = zi_q * zi_q;
      zri     = zr_q * zi_q;
      diff_w  = zr2 - zi2;
      twice_w = zri;
      twice_w = twice_w <<< 1;
      mag_w   = zr2 + zi2;
      zr_nxt  = WIDTH'(diff_w >>> FRAC) + cr_q;
      zi_nxt  = WIDTH'(twice_w >>> FRAC) + ci_q;
   end

   always_comb begin
      state_d = state_q;
      zr_d    = zr_q;
      zi_d    = zi_q;
      cr_d    = cr_q;
      ci_d    = ci_q;
      cnt_d   = cnt_q;
      max_d   = max_q;
      iter_d  = iter_q;
      esc_d   = esc_q;
      crb_d   = crb_q;
      cib_d   = cib_q;

      if (shift_en) begin
         crb_d = {cr_in, crb_q[WIDTH-1:IN_W]};
         cib_d = {ci_in, cib_q[WIDTH-1:IN_W]};
      end

      unique case (state_q)
         S_RUN: begin
            if (mag_w >= FOUR) begin
               esc_d   = 1'b1;
               iter_d  = cnt_q;
               state_d = S_DONE;
            end else if (cnt_q == max_q) begin
               esc_d   = 1'b0;
               iter_d  = cnt_q;
               state_d = S_DONE;
            end else begin
               zr_d  = zr_nxt;
               zi_d  = zi_nxt;
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (state_q == S_DONE) state_d = S_IDLE;
            // C takes the buffer contents from before any same-cycle shift.
            if (start) begin
               cr_d    = crb_q;
               ci_d    = cib_q;
               zr_d    = '0;
               zi_d    = '0;
               cnt_d   = '0;
               max_d   = max_iter;
               state_d = S_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         zr_q    <= '0;
         zi_q    <= '0;
         cr_q    <= '0;
         ci_q    <= '0;
         crb_q   <= '0;
         cib_q   <= '0;
         cnt_q   <= '0;
         max_q   <= '0;
         iter_q  <= '0;
         esc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         zr_q    <= zr_d;
         zi_q    <= zi_d;
         cr_q    <= cr_d;
         ci_q    <= ci_d;
         crb_q   <= crb_d;
         cib_q   <= cib_d;
         cnt_q   <= cnt_d;
         max_q   <= max_d;
         iter_q  <= iter_d;
         esc_q   <= esc_d;
      end
   end

   assign busy       = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign escaped    = esc_q;
   assign iter_count = iter_q;

endmodule
